// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a single variable-latency data memory.
// Optional BUSY timeout/abort is compiled in with `define DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_stall,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_ready,
  output logic                  err,
  output logic                  o_dbg_state
);

  // Handshake: a requester raises mN_req and holds it (with stable addr/data)
  // until mN_ack pulses for one cycle; the memory holds mem_* stable until it
  // answers with mem_ready, which is only honoured while BUSY.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_gnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;
  logic                  r_m0_ack;
  logic                  r_m1_ack;

  logic                  w_any_ack;
  logic                  w_grant;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_any_ack = r_m0_ack | r_m1_ack;
  // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
  assign w_grant   = m0_req ? (m1_req & ~r_last_grant) : 1'b1;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err;
  logic             w_timeout;

  assign w_timeout = (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) & ~mem_ready;
  assign w_done    = mem_ready | w_timeout;
  // An aborted read returns zero rather than whatever is on the bus.
  assign w_rdata   = mem_ready ? mem_read_data : '0;
  assign err       = r_err;
`else
  assign w_done    = mem_ready;
  assign w_rdata   = mem_read_data;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      r_to_cnt     <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      r_err    <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          // Requests seen during an ack cycle are stale and must not re-issue.
          if ((m0_req | m1_req) && !w_any_ack) begin
            r_gnt        <= w_grant;
            r_last_grant <= w_grant;
            r_mem_addr   <= w_grant ? m1_addr : m0_addr;
            if (!w_grant) begin
              r_mem_wdata <= m0_wdata;
            end
            r_we         <= ~w_grant & m0_we;
            r_mem_read   <= w_grant | ~m0_we;
            r_mem_write  <= ~w_grant & m0_we;
            r_state      <= S_BUSY;
`ifdef DMEM_ARB_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_gnt) begin
              r_m1_ack <= 1'b1;
              if (!r_we) begin
                r_m1_rdata <= w_rdata;
              end
            end else begin
              r_m0_ack <= 1'b1;
              if (!r_we) begin
                r_m0_rdata <= w_rdata;
              end
            end
`ifdef DMEM_ARB_TIMEOUT_EN
            r_err <= w_timeout;
`endif
            r_state <= S_IDLE;
          end
`ifdef DMEM_ARB_TIMEOUT_EN
          else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_rdata       = r_m0_rdata;
  assign m1_rdata       = r_m1_rdata;
  assign m0_ack         = r_m0_ack;
  assign m1_ack         = r_m1_ack;
  assign m0_stall       = m0_req & ~r_m0_ack;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter in front of the single data-memory interface.
- Port 0: the memory stage's load/store requests (read/write). Port 1: the instruction-fetch refill / secondary master (read-only).
- Round-robin grant, one outstanding access at a time, variable-latency memory via mem_ready.
- Per-port one-cycle acks, plus a stall for port 0 so the pipeline holds while the access is pending.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles before abort (used only with DMEM_ARB_TIMEOUT_EN); must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- m0_req  in  1  port 0 request; held until m0_ack.
- m0_we  in  1  port 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  port 0 address.
- m0_wdata  in  DATA_WIDTH  port 0 write data.
- m0_rdata  out  DATA_WIDTH  port 0 read data; valid while m0_ack=1.
- m0_ack  out  1  port 0 completion pulse.
- m0_stall  out  1  combinational: m0_req & ~m0_ack.
- m1_req  in  1  port 1 read request; held until m1_ack.
- m1_addr  in  ADDR_WIDTH  port 1 address.
- m1_rdata  out  DATA_WIDTH  port 1 read data; valid while m1_ack=1.
- m1_ack  out  1  port 1 completion pulse.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_write_data  out  DATA_WIDTH  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_read_data  in  DATA_WIDTH  memory read data; sampled when mem_ready=1.
- mem_ready  in  1  memory completes the current access this cycle.
- err  out  1  timeout-abort pulse, concurrent with ack.

Behaviour:
- Reset (async, rst=1): every registered output is 0, state=IDLE, last_grant=1 (so port 0 wins the first tie), timeout counter=0.
- States: IDLE, BUSY.
- IDLE, any req sampled high and no ack asserted this cycle:
  - Grant: only one requesting → that port; both → the port ≠ last_grant.
  - Next edge: latch the granted port's addr/wdata/we into mem_addr/mem_write_data; mem_read = ~we (port 1 always read); mem_write = we; last_grant = granted port; go BUSY.
- IDLE, cycle in which m0_ack or m1_ack is high: requests are ignored, so a requester lowering req in its ack cycle is never re-issued.
- BUSY:
  - mem_* outputs held stable.
  - On an edge with mem_ready=1: mem_read and mem_write→0; granted port's ack=1 for exactly one cycle; on a read, that port's rdata ← mem_read_data; go IDLE.
- rdata hold rules: rdata is unchanged on writes and holds its value after ack. The non-granted port's rdata and ack are untouched.
- Latency:
  - req high at edge E0 → mem strobe high from E1.
  - mem_ready high in the first BUSY cycle → ack high after E2.
  - Minimum spacing between back-to-back accesses: 3 cycles.
- Requester drops req while BUSY: the access completes and ack still pulses.
- Requester drops req before grant: nothing is issued.
- mem_ready while IDLE: ignored.
- rst asserted mid-access: immediate return to the reset values; no ack is generated.
- Both acks are never high in the same cycle. err is 0 except on a timeout pulse.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entering BUSY and increments each BUSY cycle without mem_ready.
  - If the counter reaches TIMEOUT_CYCLES-1 with mem_ready=0: strobes drop; granted ack=1 and err=1 for one cycle; on a read, granted rdata=0; go IDLE.
  - mem_ready in that same cycle takes precedence: normal completion, err=0.
- Without the macro: no counter; BUSY waits indefinitely; err is tied to 0.

Test Plan:
- Port 0 read, addr=0x100, mem_ready one cycle after mem_read, mem_read_data=0xDEADBEEF → mem_read high 2 cycles, m0_ack one cycle with m0_rdata=0xDEADBEEF, m0_stall high until the ack cycle.
- Port 0 write, addr=0x40, wdata=0x12345678, mem_ready in the first BUSY cycle → mem_write=1 with those values for 1 cycle; m0_ack pulses; m0_rdata unchanged.
- m0_req and m1_req asserted together after reset, held through 4 accesses, mem_ready immediate → grant order 0,1,0,1; each ack is one cycle; the acks never overlap.
- Port 1 read with mem_ready delayed 5 cycles → mem_addr/mem_read stable for all 6 BUSY cycles; m1_ack once with the correct data.
- rst pulsed mid-BUSY → all outputs 0 asynchronously, no ack; a fresh m0 request after reset is served normally.
- DMEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, mem_ready held 0 → after 16 BUSY cycles m0_ack=1, err=1, m0_rdata=0, strobes low. A separate run with mem_ready arriving in the 16th cycle → normal completion, err=0.
